// File: rtl/shift_add_mult8.sv
// Sequential unsigned shift-and-add multiplier. The product is built one partial product per
// clock using an adder made of chained 4-bit carry-lookahead slices.
module shift_add_mult8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] p_o
);

  localparam int unsigned Slices = WIDTH / 4;
  localparam int unsigned CntW   = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic [Slices:0]    carry;
  logic [WIDTH-1:0]   a_shift;
  logic [WIDTH-1:0]   q_shift;

  // One 4-bit CLA slice; returns {carry_out, sum}.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] g;
    logic [3:0] pr;
    logic [4:0] c;
    g    = x & y;
    pr   = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (pr[0] & c[0]);
    c[2] = g[1] | (pr[1] & g[0]) | (pr[1] & pr[0] & c[0]);
    c[3] = g[2] | (pr[2] & g[1]) | (pr[2] & pr[1] & g[0]) | (pr[2] & pr[1] & pr[0] & c[0]);
    c[4] = g[3] | (pr[3] & g[2]) | (pr[3] & pr[2] & g[1]) | (pr[3] & pr[2] & pr[1] & g[0]) |
           (pr[3] & pr[2] & pr[1] & pr[0] & c[0]);
    return {c[4], pr ^ c[3:0]};
  endfunction

  always_comb begin
    logic [4:0] r;
    addend   = q_q[0] ? m_q : '0;
    sum      = '0;
    carry    = '0;
    carry[0] = 1'b0;
    for (int i = 0; i < int'(Slices); i++) begin
      r              = cla4(a_q[4*i +: 4], addend[4*i +: 4], carry[i]);
      sum[4*i +: 4]  = r[3:0];
      carry[i+1]     = r[4];
    end
    // Adder carry-out lands in the top of A; the bit falling out of A enters Q.
    a_shift = {carry[Slices], sum[WIDTH-1:1]};
    q_shift = {sum[0], q_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          m_d     = a_i;
          q_d     = b_i;
          a_d     = '0;
          cnt_d   = CntW'(WIDTH);
          state_d = StRun;
        end
      end
      StRun: begin
        a_d   = a_shift;
        q_d   = q_shift;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          p_d     = {a_shift, q_shift};
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign busy_o = (state_q == StRun);
  assign done_o = (state_q == StDone);
  assign p_o    = p_q;

endmodule

// File: tb/tb_shift_add_mult8.sv
// Directed and random checks for shift_add_mult8: latency, handshake, reset abort, held start.
module tb_shift_add_mult8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [7:0]  a_i;
  logic [7:0]  b_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] p_o;

  int n_checks = 0;
  int n_pass   = 0;

  shift_add_mult8 #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .p_o     (p_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts from IDLE, returns one cycle after done (back in IDLE).
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] exp, input bit full);
    int edges;
    int busy_n;
    bit seen;
    a_i = av;
    b_i = bv;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    a_i = ~av;
    b_i = ~bv;
    edges = 0;
    busy_n = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy_o) busy_n++;
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      step();
      edges++;
    end
    check({tag, ".done_seen"}, 32'(seen), 32'd1);
    check({tag, ".p"}, 32'(p_o), 32'(exp));
    if (full) begin
      check({tag, ".latency"}, 32'(edges), 32'd8);
      check({tag, ".busy_cycles"}, 32'(busy_n), 32'd8);
      check({tag, ".busy_at_done"}, 32'(busy_o), 32'd0);
    end
    step();
    if (full) check({tag, ".done_one_cycle"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    int dn;
    int edges;
    logic [7:0] ra;
    logic [7:0] rb;

    rst = 1'b1;
    start_i = 1'b0;
    a_i = '0;
    b_i = '0;
    step();
    step();
    check("reset.busy", 32'(busy_o), 32'd0);
    check("reset.done", 32'(done_o), 32'd0);
    check("reset.p", 32'(p_o), 32'd0);
    rst = 1'b0;
    step();

    run_op("13x11", 8'd13, 8'd11, 16'h008F, 1'b1);
    run_op("255x255", 8'd255, 8'd255, 16'hFE01, 1'b1);
    run_op("0x200", 8'd0, 8'd200, 16'd0, 1'b1);
    run_op("200x0", 8'd200, 8'd0, 16'd0, 1'b1);
    run_op("1x255", 8'd1, 8'd255, 16'd255, 1'b1);
    run_op("128x2", 8'd128, 8'd2, 16'd256, 1'b1);

    // Start pulse with new operands during RUN must be ignored.
    a_i = 8'd7;
    b_i = 8'd6;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (3) step();
    a_i = 8'd9;
    b_i = 8'd9;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    dn = 0;
    for (int i = 0; i < 20 && !done_o; i++) step();
    check("ignore.done", 32'(done_o), 32'd1);
    check("ignore.p", 32'(p_o), 32'd42);
    for (int i = 0; i < 15; i++) begin
      step();
      if (done_o) dn++;
    end
    check("ignore.extra_done", 32'(dn), 32'd0);

    // Reset mid-RUN aborts.
    a_i = 8'd100;
    b_i = 8'd100;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort.busy", 32'(busy_o), 32'd0);
    check("abort.done", 32'(done_o), 32'd0);
    check("abort.p", 32'(p_o), 32'd0);
    dn = 0;
    for (int i = 0; i < 15; i++) begin
      if (done_o) dn++;
      step();
    end
    check("abort.no_done", 32'(dn), 32'd0);
    run_op("3x5", 8'd3, 8'd5, 16'd15, 1'b1);

    // Start held high: one product every 10 cycles.
    a_i = 8'd15;
    b_i = 8'd15;
    start_i = 1'b1;
    for (int i = 0; i < 30 && !done_o; i++) step();
    check("held.first_done", 32'(done_o), 32'd1);
    check("held.first_p", 32'(p_o), 32'd225);
    for (int r = 0; r < 2; r++) begin
      edges = 0;
      step();
      edges++;
      for (int i = 0; i < 30 && !done_o; i++) begin
        step();
        edges++;
      end
      check("held.period", 32'(edges), 32'd10);
      check("held.p", 32'(p_o), 32'd225);
    end
    start_i = 1'b0;
    step();
    step();

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op("rand", ra, rb, 16'(ra) * 16'(rb), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
